// File: rtl/charmatrix_scan.sv
// 5x7 character bitmap scanner: pending buffer, tear-free frame-boundary swap, row multiplexing with blanking.
// Latency: outputs registered one cycle after the scan counters; a new bitmap shows in the frame after the next swap.
// Backpressure: bitmap_ready drops while a bitmap is pending and rises the cycle after the swap. Macro CHARMATRIX_DIM_EN adds brightness dimming.
module charmatrix_scan #(
   parameter int DWELL_CYCLES = 1024,
   parameter int BLANK_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [34:0] bitmap_in,
   input  logic        bitmap_valid,
   output logic        bitmap_ready,
`ifdef CHARMATRIX_DIM_EN
   input  logic [2:0]  brightness,
`endif
   output logic [6:0]  row_sel,
   output logic [4:0]  col_data,
   output logic        frame_tick
);

   localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DW-1:0] DLAST = DW'(DWELL_CYCLES - 1);
   localparam logic [DW-1:0] BLANK = DW'(BLANK_CYCLES);

   logic [DW-1:0] dwell;
   logic [2:0]    row;
   logic [34:0]   display;
   logic [34:0]   pending;
   logic          last_dwell;
   logic          swap;
   logic          lit;
   logic [4:0]    row_bits;

   assign last_dwell = (dwell == DLAST);
   assign swap       = last_dwell && (row == 3'd6);

`ifdef CHARMATRIX_DIM_EN
   // PWM within the row: top three dwell bits against the requested level.
   assign lit = (dwell >= BLANK) && (dwell[DW-1 -: 3] <= brightness);
`else
   assign lit = (dwell >= BLANK);
`endif

   always_comb begin
      row_bits = 5'd0;
      case (row)
         3'd0:    row_bits = display[34:30];
         3'd1:    row_bits = display[29:25];
         3'd2:    row_bits = display[24:20];
         3'd3:    row_bits = display[19:15];
         3'd4:    row_bits = display[14:10];
         3'd5:    row_bits = display[9:5];
         3'd6:    row_bits = display[4:0];
         default: row_bits = 5'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dwell        <= '0;
         row          <= 3'd0;
         display      <= 35'd0;
         pending      <= 35'd0;
         bitmap_ready <= 1'b1;
         row_sel      <= 7'd0;
         col_data     <= 5'd0;
         frame_tick   <= 1'b0;
      end else begin
         if (last_dwell) begin
            dwell <= '0;
            row   <= (row == 3'd6) ? 3'd0 : row + 3'd1;
         end else begin
            dwell <= dwell + 1'b1;
         end

         frame_tick <= swap;
         row_sel    <= lit ? (7'd1 << row) : 7'd0;
         col_data   <= lit ? row_bits : 5'd0;

         // bitmap_ready doubles as the pending-empty flag, so swap and accept never overlap.
         if (swap && !bitmap_ready) begin
            display      <= pending;
            bitmap_ready <= 1'b1;
         end else if (bitmap_valid && bitmap_ready) begin
            pending      <= bitmap_in;
            bitmap_ready <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_charmatrix_scan.sv
// Bench for charmatrix_scan with DWELL_CYCLES=16, BLANK_CYCLES=2: directed steps plus random traffic against a frame-phase model.
module tb_charmatrix_scan;

   localparam int DWELL = 16;
   localparam int BLANK = 2;
   localparam int FRAME = 7 * DWELL;

   logic        clk;
   logic        rst_n;
   logic [34:0] bitmap_in;
   logic        bitmap_valid;
   logic        bitmap_ready;
   logic [6:0]  row_sel;
   logic [4:0]  col_data;
   logic        frame_tick;
`ifdef CHARMATRIX_DIM_EN
   logic [2:0]  brightness;
`endif

   charmatrix_scan #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bitmap_in    (bitmap_in),
      .bitmap_valid (bitmap_valid),
      .bitmap_ready (bitmap_ready),
`ifdef CHARMATRIX_DIM_EN
      .brightness   (brightness),
`endif
      .row_sel      (row_sel),
      .col_data     (col_data),
      .frame_tick   (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model state: phase within the frame, displayed and pending bitmaps.
   int          m_phase;
   logic [34:0] m_disp;
   logic [34:0] m_pend;
   logic        m_full;
   logic [6:0]  e_row;
   logic [4:0]  e_col;
   logic        e_tick;

   task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_disp  = 35'd0;
      m_pend  = 35'd0;
      m_full  = 1'b0;
   endtask

   task automatic tick();
      logic        v;
      logic [34:0] din;
      int          r;
      int          d;
      bit          on;
      v   = bitmap_valid;
      din = bitmap_in;
      @(posedge clk);
      r  = m_phase / DWELL;
      d  = m_phase % DWELL;
      on = (d >= BLANK);
`ifdef CHARMATRIX_DIM_EN
      on = on && ((d / 2) <= int'(brightness));
`endif
      e_tick = (m_phase == FRAME - 1);
      e_row  = on ? 7'(1 << r) : 7'd0;
      e_col  = on ? 5'((m_disp >> (30 - 5 * r)) & 35'h1F) : 5'd0;
      if (m_phase == FRAME - 1 && m_full) begin
         m_disp = m_pend;
         m_full = 1'b0;
      end else if (v && !m_full) begin
         m_pend = din;
         m_full = 1'b1;
      end
      m_phase = (m_phase + 1) % FRAME;
      #1;
      chk("row_sel", 35'(row_sel), 35'(e_row));
      chk("col_data", 35'(col_data), 35'(e_col));
      chk("frame_tick", 35'(frame_tick), 35'(e_tick));
      chk("bitmap_ready", 35'(bitmap_ready), 35'(!m_full));
   endtask

   // Advance until the outputs reflect scan phase ph.
   task automatic show(input int ph);
      int target;
      target = (ph + 1) % FRAME;
      do tick(); while (m_phase != target);
   endtask

   function automatic logic [4:0] row_of(input logic [34:0] bm, input int r);
      return 5'((bm >> (30 - 5 * r)) & 35'h1F);
   endfunction

   logic [34:0] ones;
   logic [34:0] glyph_a;
   logic [34:0] bm_b;
   logic [34:0] bm_c;
   logic [34:0] bm_d;
   int          pulses;

   initial begin
      ones    = 35'h7_FFFF_FFFF;
      glyph_a = {5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
      rst_n        = 1'b0;
      bitmap_valid = 1'b0;
      bitmap_in    = 35'd0;
`ifdef CHARMATRIX_DIM_EN
      brightness   = 3'd7;
`endif
      model_reset();

      // Reset state, then a bitmap offered on the very first cycle.
      #12;
      chk("rst_row_sel", 35'(row_sel), 35'd0);
      chk("rst_col", 35'(col_data), 35'd0);
      chk("rst_tick", 35'(frame_tick), 35'd0);
      chk("rst_ready", 35'(bitmap_ready), 35'd1);
      bitmap_valid = 1'b1;
      bitmap_in    = ones;
      #1 rst_n = 1'b1;
      tick();
      bitmap_valid = 1'b0;
      chk("t1_accept", 35'(bitmap_ready), 35'd0);
      show(FRAME - 1);
      chk("t1_swap_tick", 35'(frame_tick), 35'd1);
      show(2 * DWELL + 5);
      chk("t1_row2_sel", 35'(row_sel), 35'b0000100);
      chk("t1_row2_col", 35'(col_data), 35'h1F);
      show(3 * DWELL + 1);
      chk("t1_blank_sel", 35'(row_sel), 35'd0);
      chk("t1_blank_col", 35'(col_data), 35'd0);

      // Glyph "A": bit ordering of rows and columns.
      bitmap_valid = 1'b1;
      bitmap_in    = glyph_a;
      tick();
      bitmap_valid = 1'b0;
      show(FRAME - 1);
      show(5);
      chk("t2_row0_sel", 35'(row_sel), 35'b0000001);
      chk("t2_row0_col", 35'(col_data), 35'b01110);
      show(3 * DWELL + 9);
      chk("t2_row3_col", 35'(col_data), 35'b11111);
      show(6 * DWELL + 15);
      chk("t2_row6_sel", 35'(row_sel), 35'b1000000);
      chk("t2_row6_col", 35'(col_data), 35'b10001);

      // Second bitmap offered while pending is full.
      bm_b = {$urandom, $urandom} & 35'h7_FFFF_FFFF;
      bm_c = ~bm_b;
      bitmap_valid = 1'b1;
      bitmap_in    = bm_b;
      tick();
      bitmap_in = bm_c;
      show(FRAME - 1);
      chk("t3_ready_after_swap", 35'(bitmap_ready), 35'd1);
      tick();
      chk("t3_c_accepted", 35'(bitmap_ready), 35'd0);
      bitmap_valid = 1'b0;
      show(5);
      chk("t3_still_b", 35'(col_data), 35'(row_of(bm_b, 0)));
      show(FRAME - 1);
      show(5);
      chk("t3_now_c", 35'(col_data), 35'(row_of(bm_c, 0)));

      // Idle for three frames: image persists, one tick per frame.
      pulses = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         tick();
         if (frame_tick) pulses++;
      end
      chk("t4_pulses", 35'(pulses), 35'd3);

      // Asynchronous reset mid-row 4 with a pending bitmap.
      bm_d = {$urandom, $urandom} & 35'h7_FFFF_FFFF;
      bitmap_valid = 1'b1;
      bitmap_in    = bm_d;
      tick();
      bitmap_valid = 1'b0;
      show(4 * DWELL + 7);
      chk("t5_pre_sel", 35'(row_sel), 35'b0010000);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_sel", 35'(row_sel), 35'd0);
      chk("t5_async_col", 35'(col_data), 35'd0);
      chk("t5_async_tick", 35'(frame_tick), 35'd0);
      chk("t5_async_ready", 35'(bitmap_ready), 35'd1);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      show(5);
      chk("t5_restart_sel", 35'(row_sel), 35'b0000001);
      chk("t5_blank_disp", 35'(col_data), 35'd0);
      show(FRAME - 1);
      show(DWELL + 4);
      chk("t5_discarded", 35'(col_data), 35'd0);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         bitmap_valid = ($urandom_range(0, 5) == 0);
         bitmap_in    = {$urandom, $urandom} & 35'h7_FFFF_FFFF;
         tick();
      end
      bitmap_valid = 1'b0;

`ifdef CHARMATRIX_DIM_EN
      bitmap_valid = 1'b1;
      bitmap_in    = ones;
      do tick(); while (bitmap_ready);
      bitmap_valid = 1'b0;
      show(FRAME - 1);
      brightness = 3'd3;
      show(DWELL + 7);
      chk("t6_dim_on", 35'(row_sel), 35'b0000010);
      show(DWELL + 8);
      chk("t6_dim_off", 35'(row_sel), 35'd0);
      for (int i = 0; i < FRAME; i++) tick();
      brightness = 3'd7;
      show(DWELL + 12);
      chk("t6_full_on", 35'(col_data), 35'h1F);
      for (int i = 0; i < FRAME; i++) tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/charmatrix_scan.md
Name: charmatrix_scan

Overview:
- Downstream consumer of the 35-bit 5x7 character bitmaps produced by the character ROM.
- Accepts one bitmap through a valid/ready handshake into a pending buffer.
- Swaps the pending buffer into the display register only at frame boundaries, so there is no tearing.
- Time-multiplexes the 7 rows onto an LED matrix: one-hot row select plus 5 column bits, with an inter-row blanking gap against ghosting.

Parameters:
- DWELL_CYCLES, 1024: clock cycles each row is scanned, including blanking; must be ≥ BLANK_CYCLES+1.
- BLANK_CYCLES, 2: cycles at the start of each row during which row_sel and col_data are forced to 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- bitmap_in  in  35  character bitmap. Row r = bitmap_in[34-5r : 30-5r], r=0 is the top row. Within a row slice the MSB is column 0 (leftmost).
- bitmap_valid  in  1  bitmap_in is valid
- bitmap_ready  out  1  pending buffer empty; transfer occurs when valid && ready at a rising clk edge
- row_sel  out  7  one-hot, active-high row drive; row_sel[r] selects row r
- col_data  out  5  active-high column drive; col_data[4] = column 0
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame (swap cycle)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - display register = 0, pending empty, bitmap_ready=1.
  - row counter = 0, dwell counter = 0.
  - row_sel=0, col_data=0, frame_tick=0.
- All outputs are registered.
- After reset release, scanning starts immediately at row 0, dwell 0.
- Dwell counter:
  - Counts 0..DWELL_CYCLES-1.
  - At DWELL_CYCLES-1 it wraps to 0 and the row counter advances 0→1→…→6→0.
  - The counter is wide enough for DWELL_CYCLES-1 (clog2).
- Outputs for row r, dwell count d, registered one cycle after the counter state:
  - d < BLANK_CYCLES: row_sel=0, col_data=0.
  - otherwise: row_sel = 1<<r, col_data = display row r slice.
- Frame period = 7*DWELL_CYCLES cycles.
- Swap cycle = the cycle with row=6, d=DWELL_CYCLES-1. On that edge:
  - If pending is full, display ← pending and pending becomes empty.
  - If pending is empty, display is unchanged; the last character persists indefinitely.
  - frame_tick is high for exactly this one cycle (registered alongside the outputs).
- Handshake:
  - bitmap_ready = !pending_full (registered state).
  - An accept sets pending_full and captures bitmap_in.
  - bitmap_in is not sampled when ready=0; valid may stay high across waits.
- Simultaneous swap and accept:
  - Impossible when pending is full, since ready=0. ready rises the cycle after the swap.
  - When pending is empty at the swap, an accept in the swap cycle fills pending for the *next* frame; the display is not updated this frame.
- Latency: an accepted bitmap first appears on col_data at row 0 after BLANK_CYCLES, in the frame following the next swap.
- Reset mid-frame: immediate return to reset state; the pending bitmap is discarded.

Optional Feature:
- Macro CHARMATRIX_DIM_EN.
- When defined:
  - Adds input port brightness[2:0].
  - DWELL_CYCLES must be a power of two ≥ 16.
  - Within the non-blank part of a row, outputs are driven only while dwell_count[MSB:MSB-2] ≤ brightness; otherwise row_sel=0 and col_data=0.
  - brightness=7 gives full on (identical to the feature-off output).
  - brightness is sampled every cycle; no synchronisation is required.
- When undefined: no brightness port, full-duty output.

Test Plan (DWELL_CYCLES=16, BLANK_CYCLES=2):
1. Reset, then present bitmap 35'h7_FFFF_FFFF with valid=1 → accepted the first cycle (ready drops).
   - After swap at cycle 111 (row 6, d=15), frame_tick pulses once.
   - Next frame: each row shows col_data=5'h1F with row_sel one-hot for cycles d=2..15; both are 0 for d=0..1.
2. Load "A" pattern (row0=01110, row3=11111, row6=10001) → row_sel=7'b0000001 shows col_data=5'b01110, row 3 shows 5'b11111, row 6 shows 5'b10001. This verifies bit ordering.
3. Offer a second bitmap while pending is full → ready stays 0 until the cycle after the next swap.
   - Then it is accepted.
   - The display changes exactly one frame later.
4. Hold valid=0 across 3 frames after one load → display keeps the same bitmap; frame_tick pulses every 112 cycles.
5. Assert rst_n=0 mid-row 4 with pending full → row_sel, col_data and frame_tick go to 0 without waiting for clk. ready=1. After release, the display is blank (0) and the scan restarts at row 0.
6. CHARMATRIX_DIM_EN with brightness=3 → in each row, outputs are active only for d=2..7 and zero for d=8..15. With brightness=7, output is identical to the feature-off case.
